spi_input_conditioner: RTL and testbench
========================================

# spi_input_conditioner

Front-end conditioning stage for the SPI slave: takes the raw, asynchronous `sclk`, `cs` and `mosi` pins, synchronizes them into the `clk` domain, debounces each one, and produces the single-cycle edge strobes and clean levels that the SPI slave control FSM consumes (`clkedge`, `cs`, serial data into the MOSI shift register). It sits directly upstream of that FSM and its shift registers. Everything downstream sees only `clk`-synchronous, glitch-free signals.

## Interface
- `SYNC_STAGES`, 2, number of synchronizer flops per input (legal range 2..4)
- `WAIT`, 3, debounce count; a synchronized level must differ from the conditioned level for `WAIT+1` consecutive cycles to be accepted (legal range 0..15)
- `CNT_W`, 4, debounce counter width; `WAIT` < 2^`CNT_W`
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sclk_pin`  in  1  raw SPI clock pin
- `cs_pin`  in  1  raw chip-select pin, active low
- `mosi_pin`  in  1  raw MOSI pin
- `sclk_rise`  out  1  one-cycle strobe: conditioned sclk went 0→1
- `sclk_fall`  out  1  one-cycle strobe: conditioned sclk went 1→0
- `cs_cond`  out  1  conditioned chip-select level
- `cs_fall`  out  1  one-cycle strobe: conditioned cs went 1→0 (frame start)
- `cs_rise`  out  1  one-cycle strobe: conditioned cs went 0→1 (frame end)
- `mosi_cond`  out  1  conditioned MOSI level
- `mosi_bit`  out  1  MOSI value captured at sclk rise
- `mosi_valid`  out  1  one-cycle strobe: `mosi_bit` updated

## Operation
- Three identical channels (sclk, cs, mosi): `SYNC_STAGES`-deep flop chain → debouncer → edge detector.
- Debouncer per channel, state: `cond` (registered), `cnt` (`CNT_W` bits):
  - `synced == cond`: `cnt <= 0`.
  - `synced != cond` and `cnt != WAIT`: `cnt <= cnt + 1`.
  - `synced != cond` and `cnt == WAIT`: `cond <= synced`, `cnt <= 0`, assert matching rise/fall strobe for exactly that one cycle.
- Any return of `synced` to `cond` before acceptance clears `cnt`; glitches shorter than `WAIT+1` cycles produce no output change and no strobe.
- `WAIT = 0`: `cond` follows `synced` one cycle later.
- MOSI capture: on the cycle `sclk_rise` is high and `cs_cond == 0`, register `mosi_bit <= mosi_cond` and pulse `mosi_valid` the following cycle. `sclk_rise` while `cs_cond == 1` does not touch `mosi_bit` or `mosi_valid`.
- `mosi_cond` flipping in the same cycle as `sclk_rise`: `mosi_bit` captures the pre-flip (registered) `mosi_cond`.
- `sclk_rise`/`sclk_fall` are not gated by cs; gating by cs is the FSM's job.
- Strobes never assert two cycles in a row for the same channel (debouncer needs ≥1 cycle to re-count).

## Timing
- Reset (`rst_n` low, async): sclk chain/`cond` = 0; cs chain/`cond` = 1 (deselected); mosi chain/`cond` = 0; all counters 0; all strobes 0; `mosi_bit` = 0; `mosi_valid` = 0. Outputs reflect reset immediately, not at next edge.
- Reset deassertion mid-frame: block restarts from reset values; a pin already low on `cs_pin` yields `cs_fall` after the normal latency.
- Latency pin → `cond`/strobe: `SYNC_STAGES + WAIT + 1` rising edges after the pin change is first sampled; defaults give 6 cycles.
- `mosi_valid` asserts 1 cycle after `sclk_rise` (default: 7 cycles after the sclk pin edge).
- Minimum accepted pulse width on any pin: `WAIT+1` clk cycles; required SPI half-period ≥ `WAIT+2` clk cycles.
- All outputs registered; no combinational path from pins to outputs.

## Test plan
- Reset: hold `rst_n`=0, pins arbitrary → `cs_cond`=1, `mosi_cond`=0, all strobes 0; release with pins idle → no strobes for 20 cycles.
- Latency (defaults): `cs_pin` 1→0 held → `cs_fall` high exactly on 6th edge for one cycle, `cs_cond`=0 from then on; `cs_pin` 0→1 → `cs_rise` 6 edges later.
- Glitch rejection (`WAIT`=3): `sclk_pin` pulse 3 cycles wide → no `sclk_rise`; 4 cycles wide → one `sclk_rise` and, on return, one `sclk_fall`.
- Byte capture: cs low, shift 0xA5 MSB-first with 8-cycle half-periods → 8 `mosi_valid` pulses, `mosi_bit` sequence 1,0,1,0,0,1,0,1.
- Deselected clocks: cs high, 4 sclk pulses → 4 `sclk_rise`, zero `mosi_valid`, `mosi_bit` unchanged.
- Async reset mid-count: assert `rst_n` while sclk counter at 2 → outputs return to reset values within the same cycle, no strobe after release until a fresh full debounce.

Source files
------------

// File: rtl/spi_input_conditioner.sv
// SPI slave front end: synchronizes, debounces and edge-detects the raw
// sclk/cs/mosi pins, and captures MOSI on each selected sclk rise.
module spi_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int WAIT        = 3,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_pin,
  input  logic cs_pin,
  input  logic mosi_pin,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_cond,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_cond,
  output logic mosi_bit,
  output logic mosi_valid
);

  // channel 0 = sclk, 1 = cs, 2 = mosi; cs idles high (deselected)
  localparam logic [2:0] RST_LVL = 3'b010;
  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

  logic [2:0] pins;
  logic [2:0] synced;
  logic [2:0] cond;
  logic [2:0] rise;
  logic [2:0] fall;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [CNT_W-1:0] cnt [3];
  logic cap;

  assign pins = {mosi_pin, cs_pin, sclk_pin};

  always_comb begin
    synced = '0;
    for (int i = 0; i < 3; i++) begin
      synced[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {SYNC_STAGES{RST_LVL[i]}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pins[i]};
      end
    end
  end

  // A new level is accepted only after WAIT+1 consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond <= RST_LVL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < 3; i++) begin
        if (synced[i] == cond[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != WAIT_C) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else begin
          cond[i] <= synced[i];
          cnt[i]  <= '0;
          rise[i] <= synced[i];
          fall[i] <= ~synced[i];
        end
      end
    end
  end

  // Registered cond is used, so a same-cycle mosi flip is not seen.
  assign cap = rise[0] & ~cond[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_bit   <= 1'b0;
      mosi_valid <= 1'b0;
    end else begin
      mosi_valid <= cap;
      if (cap) begin
        mosi_bit <= cond[2];
      end
    end
  end

  assign sclk_rise = rise[0];
  assign sclk_fall = fall[0];
  assign cs_cond   = cond[1];
  assign cs_fall   = fall[1];
  assign cs_rise   = rise[1];
  assign mosi_cond = cond[2];

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Self-checking bench for spi_input_conditioner: directed scenarios plus
// random pin activity against a sample-window reference model.
module tb_spi_input_conditioner;

  localparam int S = 2;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_pin = 1'b0;
  logic cs_pin = 1'b1;
  logic mosi_pin = 1'b0;
  logic sclk_rise, sclk_fall, cs_cond, cs_fall;
  logic cs_rise, mosi_cond, mosi_bit, mosi_valid;

  int errs = 0;
  int checks = 0;

  spi_input_conditioner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk_pin   (sclk_pin),
    .cs_pin     (cs_pin),
    .mosi_pin   (mosi_pin),
    .sclk_rise  (sclk_rise),
    .sclk_fall  (sclk_fall),
    .cs_cond    (cs_cond),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise),
    .mosi_cond  (mosi_cond),
    .mosi_bit   (mosi_bit),
    .mosi_valid (mosi_valid)
  );

  always #5 clk = ~clk;

  logic [7:0] outs;
  assign outs = {sclk_rise, sclk_fall, cs_cond, cs_fall,
                 cs_rise, mosi_cond, mosi_bit, mosi_valid};

  // model state: hist[c][k] = pin sampled k+1 edges ago
  bit hist [3][16];
  bit mcond [3];
  bit mrise [3];
  bit mfall [3];
  bit mbit;
  bit mvalid;
  bit rst_lvl [3] = '{1'b0, 1'b1, 1'b0};

  int cyc;
  int n_srise, n_sfall, n_cfall, n_crise, n_valid;
  int first_srise, first_cfall, first_crise;
  logic [7:0] shreg;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  function automatic logic [7:0] exp_vec();
    return {mrise[0], mfall[0], mcond[1], mfall[1],
            mrise[1], mcond[2], mbit, mvalid};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 16; k++) hist[c][k] = rst_lvl[c];
      mcond[c] = rst_lvl[c];
      mrise[c] = 1'b0;
      mfall[c] = 1'b0;
    end
    mbit = 1'b0;
    mvalid = 1'b0;
  endtask

  task automatic model_step();
    bit pin [3];
    bit acc;
    pin[0] = sclk_pin;
    pin[1] = cs_pin;
    pin[2] = mosi_pin;
    if (mrise[0] && !mcond[1]) begin
      mbit = mcond[2];
      mvalid = 1'b1;
    end else begin
      mvalid = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      // accept when the last W+1 synchronized samples all oppose cond
      acc = 1'b1;
      for (int k = 0; k <= W; k++) begin
        if (hist[c][S-1+k] == mcond[c]) acc = 1'b0;
      end
      mrise[c] = acc && !mcond[c];
      mfall[c] = acc && mcond[c];
      if (acc) mcond[c] = !mcond[c];
      for (int k = 15; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = pin[c];
    end
  endtask

  task automatic clr_counts();
    cyc = 0;
    n_srise = 0; n_sfall = 0; n_cfall = 0; n_crise = 0; n_valid = 0;
    first_srise = -1; first_cfall = -1; first_crise = -1;
  endtask

  task automatic tick(input logic s, input logic c, input logic m);
    @(negedge clk);
    sclk_pin = s;
    cs_pin = c;
    mosi_pin = m;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    cyc++;
    chk("outs", {24'd0, outs}, {24'd0, exp_vec()});
    if (sclk_rise) begin
      n_srise++;
      if (first_srise < 0) first_srise = cyc;
    end
    if (sclk_fall) n_sfall++;
    if (cs_fall) begin
      n_cfall++;
      if (first_cfall < 0) first_cfall = cyc;
    end
    if (cs_rise) begin
      n_crise++;
      if (first_crise < 0) first_crise = cyc;
    end
    if (mosi_valid) begin
      n_valid++;
      shreg = {shreg[6:0], mosi_bit};
    end
  endtask

  task automatic repeat_tick(input int n, input logic s, input logic c,
                             input logic m);
    for (int i = 0; i < n; i++) tick(s, c, m);
  endtask

  initial begin
    logic [7:0] byte_v;
    model_reset();
    shreg = '0;
    clr_counts();

    // reset with arbitrary pins
    for (int i = 0; i < 4; i++) begin
      tick(1'($urandom), 1'($urandom), 1'($urandom));
    end
    chk("reset_vec", {24'd0, outs}, 32'h20);
    #1 rst_n = 1'b1;

    // idle after release
    clr_counts();
    repeat_tick(20, 1'b0, 1'b1, 1'b0);
    chk("idle_strobes", n_srise + n_sfall + n_cfall + n_crise + n_valid, 0);

    // cs latency
    clr_counts();
    repeat_tick(10, 1'b0, 1'b0, 1'b0);
    chk("cs_fall_lat", first_cfall, 6);
    chk("cs_fall_cnt", n_cfall, 1);
    chk("cs_cond_low", cs_cond, 0);
    clr_counts();
    repeat_tick(10, 1'b0, 1'b1, 1'b0);
    chk("cs_rise_lat", first_crise, 6);
    chk("cs_rise_cnt", n_crise, 1);

    // glitch rejection
    clr_counts();
    repeat_tick(3, 1'b1, 1'b1, 1'b0);
    repeat_tick(10, 1'b0, 1'b1, 1'b0);
    chk("glitch3_rise", n_srise, 0);
    chk("glitch3_fall", n_sfall, 0);
    clr_counts();
    repeat_tick(4, 1'b1, 1'b1, 1'b0);
    repeat_tick(10, 1'b0, 1'b1, 1'b0);
    chk("pulse4_rise", n_srise, 1);
    chk("pulse4_fall", n_sfall, 1);

    // byte capture
    repeat_tick(10, 1'b0, 1'b0, 1'b0);
    clr_counts();
    byte_v = 8'hA5;
    shreg = '0;
    for (int b = 7; b >= 0; b--) begin
      repeat_tick(8, 1'b0, 1'b0, byte_v[b]);
      repeat_tick(8, 1'b1, 1'b0, byte_v[b]);
    end
    repeat_tick(10, 1'b0, 1'b0, 1'b0);
    chk("byte_valid_cnt", n_valid, 8);
    chk("byte_value", {24'd0, shreg}, 32'hA5);

    // deselected clocks
    repeat_tick(10, 1'b0, 1'b1, 1'b0);
    clr_counts();
    for (int p = 0; p < 4; p++) begin
      repeat_tick(8, 1'b1, 1'b1, 1'b0);
      repeat_tick(8, 1'b0, 1'b1, 1'b0);
    end
    repeat_tick(4, 1'b0, 1'b1, 1'b0);
    chk("desel_rise", n_srise, 4);
    chk("desel_valid", n_valid, 0);
    chk("desel_bit", mosi_bit, 1);

    // async reset mid-count
    repeat_tick(10, 1'b0, 1'b0, 1'b1);
    repeat_tick(4, 1'b1, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("async_rst", {24'd0, outs}, 32'h20);
    model_reset();
    repeat_tick(2, 1'b1, 1'b0, 1'b1);
    #1 rst_n = 1'b1;
    clr_counts();
    repeat_tick(10, 1'b1, 1'b0, 1'b1);
    chk("rst_srise_lat", first_srise, 6);
    chk("rst_cfall_lat", first_cfall, 6);

    // random pin activity
    for (int seg = 0; seg < 60; seg++) begin
      logic s, c, m;
      int len;
      s = 1'($urandom);
      c = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      m = 1'($urandom);
      len = $urandom_range(1, 10);
      repeat_tick(len, s, c, m);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
